// File: rtl/bcedn_frame_ctrl_pkg.sv
// Shared types and default frame geometry for the BCEDN frame sequencer.
package bcedn_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned DEF_IN_BEATS  = 786432;
    localparam int unsigned DEF_OUT_BEATS = 262144;
    localparam int unsigned DEF_CNT_W     = 20;
    localparam int unsigned DEF_TIMEOUT   = 65536;

endpackage

// File: rtl/bcedn_frame_if.sv
// Host stream / datapath FIFO handshake bundle seen by the frame sequencer.
interface bcedn_frame_if;
    logic src_valid;
    logic src_ready;
    logic fifo_wfull;
    logic in_en;
    logic out_en;

    modport master (
        output src_valid,
        output fifo_wfull,
        output out_en,
        input  src_ready,
        input  in_en
    );

    modport slave (
        input  src_valid,
        input  fifo_wfull,
        input  out_en,
        output src_ready,
        output in_en
    );
endinterface

// File: rtl/bcedn_beat_counter.sv
// Saturating beat counter with synchronous clear and last/full flags.
module bcedn_beat_counter #(
    parameter int unsigned CNT_W = 20,
    parameter int unsigned SAT   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last_c,
    output logic             full_c
);

    assign last_c = (cnt == CNT_W'(SAT - 1));
    assign full_c = (cnt == CNT_W'(SAT));

    // Clear wins over increment; holding at SAT keeps the count from wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !full_c) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bcedn_frame_ctrl.sv
// Frame sequencer: gates host beats into the datapath FIFO, launches one stage per
// frame, counts input/output beats and reports done or a sticky error.
module bcedn_frame_ctrl
    import bcedn_frame_ctrl_pkg::*;
#(
    parameter int unsigned IN_BEATS  = DEF_IN_BEATS,
    parameter int unsigned OUT_BEATS = DEF_OUT_BEATS,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    bcedn_frame_if.slave     bus,
    input  logic             start,
    output logic             stage_start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] in_cnt,
    output logic [CNT_W-1:0] out_cnt
);

    localparam int unsigned WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e              state_q, state_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                err_d, done_d, stage_start_d;
    logic                armed_q;
    logic                in_clr, in_inc, in_last, in_full;
    logic                out_clr, out_inc, out_last, out_full;
    logic                out_done;

    assign bus.src_ready = (state_q == ST_LOAD) && !bus.fifo_wfull;
    assign bus.in_en     = bus.src_valid && bus.src_ready;
    assign busy          = (state_q != ST_IDLE);
    assign out_done      = out_full || (bus.out_en && out_last);

    bcedn_beat_counter #(.CNT_W(CNT_W), .SAT(IN_BEATS)) u_in_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (in_clr),
        .inc    (in_inc),
        .cnt    (in_cnt),
        .last_c (in_last),
        .full_c (in_full)
    );

    bcedn_beat_counter #(.CNT_W(CNT_W), .SAT(OUT_BEATS)) u_out_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (out_clr),
        .inc    (out_inc),
        .cnt    (out_cnt),
        .last_c (out_last),
        .full_c (out_full)
    );

    // State and registered outputs; armed_q blocks a start on the release edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wdog_q      <= '0;
            err         <= 1'b0;
            done        <= 1'b0;
            stage_start <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            err         <= err_d;
            done        <= done_d;
            stage_start <= stage_start_d;
            armed_q     <= 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        wdog_d        = wdog_q;
        err_d         = err;
        done_d        = 1'b0;
        stage_start_d = 1'b0;
        in_clr        = 1'b0;
        in_inc        = 1'b0;
        out_clr       = 1'b0;
        out_inc       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && armed_q) begin
                    state_d       = ST_LOAD;
                    in_clr        = 1'b1;
                    out_clr       = 1'b1;
                    wdog_d        = '0;
                    err_d         = 1'b0;
                    stage_start_d = 1'b1;
                end else if (bus.out_en) begin
                    err_d = 1'b1;
                end
            end

            ST_LOAD: begin
                in_inc = bus.in_en;
                // Output completing before input is an overrun; counter saturates.
                if (bus.out_en) begin
                    out_inc = 1'b1;
                    if (out_last || out_full) begin
                        err_d = 1'b1;
                    end
                end
                if ((bus.in_en && in_last) || in_full) begin
                    if (out_done) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                        wdog_d  = '0;
                    end
                end
            end

            ST_DRAIN: begin
                if (bus.out_en) begin
                    out_inc = 1'b1;
                    wdog_d  = '0;
                    if (out_last) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.out_en) begin
                    err_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bcedn_frame_ctrl.sv
// Scoreboard bench for bcedn_frame_ctrl with a small frame geometry.
module tb_bcedn_frame_ctrl;

    localparam int unsigned IN_B  = 8;
    localparam int unsigned OUT_B = 4;
    localparam int unsigned TMO   = 16;
    localparam int unsigned CW    = 20;

    typedef struct {
        int in_c;
        int out_c;
        int e;
        int beats;
        int ss;
        int lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stage_start, busy, done, err;
    logic [CW-1:0] in_cnt, out_cnt;

    bcedn_frame_if bus ();

    bcedn_frame_ctrl #(
        .IN_BEATS (IN_B),
        .OUT_BEATS(OUT_B),
        .CNT_W    (CW),
        .TIMEOUT  (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .start      (start),
        .stage_start(stage_start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .in_cnt     (in_cnt),
        .out_cnt    (out_cnt)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t expq[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: tallies beats and stage pulses per frame, checks each done against the queue.
    int cyc = 0, beats = 0, ss = 0, last_in = 0;
    always @(negedge clk) begin
        exp_t x;
        cyc++;
        if (!rst) begin
            beats = 0;
            ss    = 0;
        end else begin
            if (stage_start) ss++;
            if (bus.in_en) begin
                beats++;
                last_in = cyc;
            end
            if (done) begin
                if (expq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    x = expq.pop_front();
                    chk("done_in_cnt", int'(in_cnt), x.in_c);
                    chk("done_out_cnt", int'(out_cnt), x.out_c);
                    chk("done_err", int'(err), x.e);
                    chk("done_beats", beats, x.beats);
                    chk("done_stage_starts", ss, x.ss);
                    if (x.lat >= 0) chk("done_latency", cyc - last_in, x.lat);
                end
                beats = 0;
                ss    = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ic, input int oc, input int e, input int lat);
        exp_t x;
        x.in_c = ic; x.out_c = oc; x.e = e; x.beats = int'(IN_B); x.ss = 1; x.lat = lat;
        expq.push_back(x);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("stage_start_pulse", int'(stage_start), 1);
        chk("start_clears_err", int'(err), 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle_within_budget", int'(busy), 0);
    endtask

    task automatic drain_out(input int n);
        for (int i = 0; i < n; i++) begin
            bus.out_en = 1'b1;
            tick();
            bus.out_en = 1'b0;
            tick();
        end
    endtask

    task automatic nominal_frame(input bit start_in_load);
        push(int'(IN_B), int'(OUT_B), 0, -1);
        do_start();
        bus.src_valid = 1'b1;
        for (int i = 0; i < int'(IN_B); i++) begin
            if (start_in_load && i == 3) start = 1'b1;
            tick();
            start = 1'b0;
            if (i == 0) chk("stage_start_one_cycle", int'(stage_start), 0);
        end
        bus.src_valid = 1'b0;
        chk("load_in_cnt", int'(in_cnt), int'(IN_B));
        chk("drain_src_ready", int'(bus.src_ready), 0);
        drain_out(int'(OUT_B));
        wait_idle(20);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int acc;
        int k;
        rst = 1'b0;
        start = 1'b0;
        bus.src_valid = 1'b1;
        bus.fifo_wfull = 1'b0;
        bus.out_en = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_src_ready", int'(bus.src_ready), 0);
        chk("rst_in_en", int'(bus.in_en), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_in_cnt", int'(in_cnt), 0);
        chk("rst_out_cnt", int'(out_cnt), 0);
        bus.src_valid = 1'b0;
        #23 rst = 1'b1;
        tick();
        tick();

        // Spurious out_en while idle.
        bus.out_en = 1'b1;
        tick();
        bus.out_en = 1'b0;
        chk("spurious_err", int'(err), 1);
        chk("spurious_out_cnt", int'(out_cnt), 0);
        chk("spurious_busy", int'(busy), 0);

        // Nominal frame with an ignored start during LOAD.
        nominal_frame(1'b1);

        // Backpressure every third cycle.
        push(int'(IN_B), int'(OUT_B), 0, -1);
        do_start();
        bus.src_valid = 1'b1;
        acc = 0;
        k = 0;
        while (acc < int'(IN_B) && k < 40) begin
            bus.fifo_wfull = (k % 3 == 2);
            #1;
            chk("bp_in_en", int'(bus.in_en), int'(!bus.fifo_wfull));
            if (bus.in_en) acc++;
            @(posedge clk);
            #1;
            k++;
        end
        bus.src_valid = 1'b0;
        bus.fifo_wfull = 1'b0;
        chk("bp_in_cnt", int'(in_cnt), int'(IN_B));
        chk("bp_drain_entered", int'(busy && !bus.src_ready), 1);
        drain_out(int'(OUT_B));
        wait_idle(20);

        // Timeout in DRAIN: done 16 cycles after DRAIN entry.
        push(int'(IN_B), 0, 1, int'(TMO) + 1);
        do_start();
        bus.src_valid = 1'b1;
        repeat (IN_B) tick();
        bus.src_valid = 1'b0;
        wait_idle(60);
        chk("timeout_err_sticky", int'(err), 1);
        chk("timeout_out_cnt", int'(out_cnt), 0);

        // Reset mid-LOAD, then a clean frame.
        do_start();
        bus.src_valid = 1'b1;
        repeat (5) tick();
        chk("midrst_in_cnt_before", int'(in_cnt), 5);
        #2 rst = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_in_en", int'(bus.in_en), 0);
        chk("midrst_in_cnt", int'(in_cnt), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_stage_start", int'(stage_start), 0);
        bus.src_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        tick();
        tick();
        nominal_frame(1'b0);

        // Overrun: 4th out_en coincides with the 8th input beat.
        push(int'(IN_B), int'(OUT_B), 1, 1);
        do_start();
        bus.src_valid = 1'b1;
        for (int i = 0; i < int'(IN_B); i++) begin
            bus.out_en = (i % 2 == 1);
            tick();
        end
        bus.out_en = 1'b0;
        bus.src_valid = 1'b0;
        chk("overrun_err", int'(err), 1);
        chk("overrun_done_now", int'(done), 1);
        wait_idle(10);
        chk("overrun_out_cnt_hold", int'(out_cnt), int'(OUT_B));

        repeat (3) tick();
        chk("scoreboard_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
